instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 98 +++++++++
 tb/tb_instr_mem_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: downloads a length-prefixed, XOR-checksummed byte stream into instruction memory
// Ports: clk, rst (async active-low); load_start, byte_data, byte_valid in, byte_ready out (handshake);
//   imem_wr_en, imem_addr, imem_wr_data drive the memory write port; cpu_rst, load_done, load_err report status.
module instr_mem_loader #(
  parameter int WORD_LEN      = 32,
  parameter int IMEM_DEPTH    = 1024,
  parameter int IMEM_ADDR_LEN = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic [7:0]               byte_data,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     imem_wr_en,
  output logic [IMEM_ADDR_LEN-1:0] imem_addr,
  output logic [WORD_LEN-1:0]      imem_wr_data,
  output logic                     cpu_rst,
  output logic                     load_done,
  output logic                     load_err
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_t;
  state_t            state, state_nx;
  logic              rdy;
  logic              acc;
  logic              last_word;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [15:0]       len_nx;
  logic [15:0]       word_cnt;
  logic [1:0]        byte_cnt;
  logic [7:0]        chk;
  logic [WORD_LEN-9:0] word;
  // a restart pulse masks the handshake so a coincident byte is never consumed
  assign byte_ready = rdy & ~load_start;
  assign acc        = byte_valid & byte_ready;
  assign len_nx     = {len_hi, byte_data};
  assign last_word  = word_cnt == len - 16'd1;
  always_comb begin
    state_nx = state;
    if (load_start) state_nx = LEN_HI;
    else if (acc)
      case (state)
        LEN_HI:  state_nx = LEN_LO;
        LEN_LO:  state_nx = len_nx == 16'd0 ? CHECK : {16'd0, len_nx} > 32'(IMEM_DEPTH) ? ERROR : DATA;
        DATA:    state_nx = byte_cnt == 2'd3 && last_word ? CHECK : DATA;
        CHECK:   state_nx = byte_data == chk ? DONE : ERROR;
        default: state_nx = state;
      endcase
  end
  // status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rdy          <= 1'b0;
      cpu_rst      <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_addr    <= '0;
      imem_wr_data <= '0;
      len_hi       <= '0;
      len          <= '0;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      chk          <= '0;
      word         <= '0;
    end else begin
      state      <= state_nx;
      rdy        <= state_nx inside {LEN_HI, LEN_LO, DATA, CHECK};
      cpu_rst    <= state_nx != DONE;
      load_done  <= state_nx == DONE;
      load_err   <= state_nx == ERROR;
      imem_wr_en <= 1'b0;
      if (load_start) begin
        imem_addr <= '0;
        word_cnt  <= '0;
        byte_cnt  <= '0;
        chk       <= '0;
        word      <= '0;
      end else if (acc) begin
        if (state == LEN_HI) len_hi <= byte_data;
        if (state == LEN_LO) len <= len_nx;
        if (state == DATA) begin
          word     <= {word[WORD_LEN-17:0], byte_data};
          chk      <= chk ^ byte_data;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            imem_wr_en   <= 1'b1;
            imem_wr_data <= {word, byte_data};
            imem_addr    <= word_cnt[IMEM_ADDR_LEN-1:0];
            word_cnt     <= word_cnt + 16'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized self-checking bench for instr_mem_loader against a stream-level model
module tb_instr_mem_loader;
  typedef logic [31:0] wq_t[$];
  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_wr_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wr_data;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;
  int          vecs = 0;
  int          errs = 0;
  bit          gaps_on = 1'b0;
  bit          prev_we = 1'b0;
  logic [41:0] writes[$];

  instr_mem_loader dut (
    .clk(clk), .rst(rst_n), .load_start(load_start), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .imem_wr_en(imem_wr_en),
    .imem_addr(imem_addr), .imem_wr_data(imem_wr_data), .cpu_rst(cpu_rst),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (imem_wr_en) begin
      writes.push_back({imem_addr, imem_wr_data});
      vecs++;
      if (prev_we) begin
        errs++;
        $display("FAIL strobe_width: imem_wr_en high two cycles in a row at addr %0d, required single-cycle", imem_addr);
      end
    end
    prev_we = imem_wr_en;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    if (gaps_on) repeat ($urandom_range(0, 3)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data = b;
    #1;
    k = 0;
    while (!byte_ready && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    vecs++;
    if (!byte_ready) begin
      errs++;
      $display("FAIL send_byte: byte_ready=%b for byte %h after %0d cycles, required 1", byte_ready, b, k);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data = 8'($urandom);
  endtask

  task automatic start_load(input bit with_byte);
    load_start = 1'b1;
    byte_valid = with_byte;
    byte_data = 8'hAA;
    writes.delete();
    #1;
    vecs++;
    if (byte_ready !== 1'b0) begin
      errs++;
      $display("FAIL start_ready: byte_ready=%b during load_start, required 0", byte_ready);
    end
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic send_stream(input wq_t words, input logic [7:0] chk);
    logic [15:0] n;
    n = 16'(words.size());
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    foreach (words[i]) for (int j = 3; j >= 0; j--) send_byte(words[i][8*j +: 8]);
    send_byte(chk);
  endtask

  task automatic check_load(input string name, input wq_t words, input logic [7:0] chk);
    logic [7:0] x;
    bit ok;
    x = 8'h00;
    foreach (words[i]) x ^= words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    ok = x == chk;
    repeat (2) @(negedge clk);
    vecs++;
    if (writes.size() != words.size()) begin
      errs++;
      $display("FAIL %s write_count: got %0d, expected %0d", name, writes.size(), words.size());
    end
    for (int i = 0; i < words.size() && i < writes.size(); i++) begin
      vecs++;
      if (writes[i] !== {10'(i), words[i]}) begin
        errs++;
        $display("FAIL %s write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 name, i, writes[i][41:32], writes[i][31:0], i, words[i]);
      end
    end
    vecs++;
    if ({load_done, load_err, cpu_rst} !== {ok, !ok, !ok}) begin
      errs++;
      $display("FAIL %s status: done/err/cpu_rst=%b%b%b, expected %b%b%b",
               name, load_done, load_err, cpu_rst, ok, !ok, !ok);
    end
  endtask

  task automatic run_load(input string name, input wq_t words, input logic [7:0] chk);
    start_load(1'b0);
    send_stream(words, chk);
    check_load(name, words, chk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({byte_ready, imem_wr_en, imem_addr, imem_wr_data, cpu_rst, load_done, load_err} !== {2'b00, 10'd0, 32'd0, 3'b100}) begin
      errs++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h cpu_rst=%b done=%b err=%b, expected 0 0 0 0 1 0 0",
               byte_ready, imem_wr_en, imem_addr, imem_wr_data, cpu_rst, load_done, load_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if ({byte_ready, cpu_rst, load_done, load_err, writes.size() == 0} !== 5'b01001) begin
      errs++;
      $display("FAIL idle_after_reset: rdy=%b cpu_rst=%b done=%b err=%b writes=%0d, expected 0 1 0 0 0",
               byte_ready, cpu_rst, load_done, load_err, writes.size());
    end
  endtask

  task automatic test_good_load;
    wq_t w;
    w = {32'h20010005, 32'h8C220004};
    gaps_on = 1'b0;
    run_load("good_load", w, 8'h8E);
  endtask

  task automatic test_bad_checksum;
    wq_t w;
    w = {32'h20010005, 32'h8C220004};
    gaps_on = 1'b1;
    run_load("bad_checksum", w, 8'h0C);
  endtask

  task automatic test_zero_len;
    wq_t w;
    w = {};
    run_load("zero_len", w, 8'h00);
  endtask

  task automatic test_overflow;
    start_load(1'b0);
    send_byte(8'h04);
    send_byte(8'h01);
    vecs++;
    if ({load_err, load_done, byte_ready, cpu_rst} !== 4'b1001) begin
      errs++;
      $display("FAIL overflow_status: err=%b done=%b rdy=%b cpu_rst=%b, expected 1 0 0 1", load_err, load_done, byte_ready, cpu_rst);
    end
    repeat (4) @(negedge clk);
    vecs++;
    if (writes.size() != 0) begin
      errs++;
      $display("FAIL overflow_writes: got %0d writes, expected 0", writes.size());
    end
  endtask

  task automatic test_restart;
    wq_t w;
    w = {32'($urandom)};
    start_load(1'b0);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    start_load(1'b1);
    send_stream(w, w[0][31:24] ^ w[0][23:16] ^ w[0][15:8] ^ w[0][7:0]);
    check_load("restart", w, w[0][31:24] ^ w[0][23:16] ^ w[0][15:8] ^ w[0][7:0]);
  endtask

  task automatic test_random;
    gaps_on = 1'b1;
    for (int r = 0; r < 8; r++) begin
      wq_t w;
      logic [7:0] x;
      x = 8'h00;
      repeat ($urandom_range(1, 8)) begin
        w.push_back($urandom);
        x ^= w[$][31:24] ^ w[$][23:16] ^ w[$][15:8] ^ w[$][7:0];
      end
      if ($urandom_range(0, 2) == 0) x ^= 8'($urandom_range(1, 255));
      run_load($sformatf("random%0d", r), w, x);
    end
  endtask

  task automatic test_max_len;
    wq_t w;
    logic [7:0] x;
    x = 8'h00;
    gaps_on = 1'b0;
    repeat (1024) begin
      w.push_back($urandom);
      x ^= w[$][31:24] ^ w[$][23:16] ^ w[$][15:8] ^ w[$][7:0];
    end
    run_load("max_len", w, x);
  endtask

  task automatic test_async_reset;
    wq_t w;
    gaps_on = 1'b1;
    start_load(1'b0);
    send_byte(8'h00);
    send_byte(8'h04);
    repeat (6) send_byte(8'($urandom));
    #3;
    rst_n = 1'b0;
    writes.delete();
    #1;
    vecs++;
    if ({byte_ready, imem_wr_en, imem_addr, imem_wr_data, cpu_rst, load_done, load_err} !== {2'b00, 10'd0, 32'd0, 3'b100}) begin
      errs++;
      $display("FAIL async_reset_outputs: rdy=%b we=%b addr=%h data=%h cpu_rst=%b done=%b err=%b, expected 0 0 0 0 1 0 0",
               byte_ready, imem_wr_en, imem_addr, imem_wr_data, cpu_rst, load_done, load_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      byte_valid = 1'($urandom);
      byte_data = 8'($urandom);
      vecs++;
      if (byte_ready !== 1'b0) begin
        errs++;
        $display("FAIL post_reset_ready: byte_ready=%b before load_start, required 0", byte_ready);
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    vecs++;
    if (writes.size() != 0 || load_done !== 1'b0 || load_err !== 1'b0) begin
      errs++;
      $display("FAIL post_reset_idle: writes=%0d done=%b err=%b, expected 0 0 0", writes.size(), load_done, load_err);
    end
    w = {32'($urandom), 32'($urandom)};
    run_load("after_reset", w, w[0][31:24] ^ w[0][23:16] ^ w[0][15:8] ^ w[0][7:0] ^ w[1][31:24] ^ w[1][23:16] ^ w[1][15:8] ^ w[1][7:0]);
  endtask

  initial begin
    rst_n = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    test_reset;
    test_good_load;
    test_bad_checksum;
    test_overflow;
    test_zero_len;
    test_restart;
    test_random;
    test_max_len;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
